shift_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter for the ALU/execute path. Generalises the single-cycle 32-bit

---
 rtl/shift_pipe.sv | 160 ++++++++++++++++
 tb/tb_shift_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter with valid/ready handshake and tag sideband
//
// Purpose: shifts in_a by in_shamt using log2(WIDTH) mux levels (1,2,4,... LSB of
//   shamt first), spread over STAGES register stages, ceil(SHW/STAGES) levels per
//   stage with the last stage taking the remainder. Output is fully registered.
// Optional feature macro: SHIFT_PIPE_ROTATE_EN (op 11 = rotate right; otherwise
//   op 11 completes normally with a zero result and no rotate muxes exist).
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   flush                  synchronous kill of every in-flight operation
//   in_valid/in_ready      input handshake
//   in_a, in_shamt, in_op  operand, shift amount, op (00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   in_tag                 sideband returned unchanged with the result
//   out_valid/out_ready    output handshake
//   out_data, out_tag      result and its tag, held stable while stalled
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag
);

  // mux levels handled per stage
  localparam int LPS = (SHW + STAGES - 1) / STAGES;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_sg;
  logic [WIDTH-1:0]  d_q     [STAGES];
  logic [WIDTH-1:0]  src_d   [STAGES];
  logic [WIDTH-1:0]  nxt_d   [STAGES];
  logic [SHW-1:0]    sh_q    [STAGES];
  logic [SHW-1:0]    src_sh  [STAGES];
  logic [1:0]        op_q    [STAGES];
  logic [1:0]        src_op  [STAGES];
  logic              sg_q    [STAGES];
  logic [TAGW-1:0]   tag_q   [STAGES];
  logic [TAGW-1:0]   src_tag [STAGES];
  logic [WIDTH-1:0]  in_d0;

  // Applies the mux levels lo..hi-1 selected by the shamt bits. The sign bit is
  // the original operand MSB, carried along so SRA fill stays correct even after
  // earlier levels have already shifted it out of position.
  function automatic logic [WIDTH-1:0] shift_levels(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   sh,
    input logic [1:0]       op,
    input logic             sgn,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] r;
    r = d;
    for (int j = 0; j < SHW; j++) begin
      if (j >= lo && j < hi && sh[j]) begin
        case (op)
          2'b00:   r = r << (1 << j);
          2'b01:   r = r >> (1 << j);
          2'b10:   r = (r >> (1 << j)) | (sgn ? ~({WIDTH{1'b1}} >> (1 << j)) : '0);
`ifdef SHIFT_PIPE_ROTATE_EN
          2'b11:   r = (r >> (1 << j)) | (r << (WIDTH - (1 << j)));
`endif
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

`ifdef SHIFT_PIPE_ROTATE_EN
  assign in_d0 = in_a;
`else
  // Without rotate support op 11 carries a zero operand, so it emerges as zero
  // after travelling the pipe with normal latency and its tag.
  assign in_d0 = (in_op == 2'b11) ? '0 : in_a;
`endif

  // A stage can take new contents when it is empty or when some stage downstream
  // of it is empty (or the consumer is taking the last one) so everything moves up.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc    = acc || !v_q[k];
      rdy[k] = acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * LPS;
    localparam int HI = ((k + 1) * LPS < SHW) ? (k + 1) * LPS : SHW;
    if (k == 0) begin : g_head
      assign src_v[k]   = in_valid;
      assign src_d[k]   = in_d0;
      assign src_sh[k]  = in_shamt;
      assign src_op[k]  = in_op;
      assign src_sg[k]  = in_a[WIDTH-1];
      assign src_tag[k] = in_tag;
    end else begin : g_link
      assign src_v[k]   = v_q[k-1];
      assign src_d[k]   = d_q[k-1];
      assign src_sh[k]  = sh_q[k-1];
      assign src_op[k]  = op_q[k-1];
      assign src_sg[k]  = sg_q[k-1];
      assign src_tag[k] = tag_q[k-1];
    end
    assign nxt_d[k] = shift_levels(src_d[k], src_sh[k], src_op[k], src_sg[k], LO, HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k]   <= '0;
        sh_q[k]  <= '0;
        op_q[k]  <= '0;
        sg_q[k]  <= 1'b0;
        tag_q[k] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            d_q[k]   <= nxt_d[k];
            sh_q[k]  <= src_sh[k];
            op_q[k]  <= src_op[k];
            sg_q[k]  <= src_sg[k];
            tag_q[k] <= src_tag[k];
          end
        end
      end
    end
  end

  // flush empties every stage, so an input can be offered (and discarded) that cycle
  assign in_ready  = rdy[0] || flush;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - scoreboard bench for shift_pipe (WIDTH=32, STAGES=2, TAGW=5)
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, out_data;
  logic [4:0]  in_shamt, in_tag, out_tag;
  logic [1:0]  in_op;

  logic [36:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

`ifdef SHIFT_PIPE_ROTATE_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                      input logic [4:0] tag, input logic [31:0] exp);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_shamt = sh;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        chk("send_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (!flush) sb.push_back({tag, exp});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 || out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        chk("drain_timeout", 1, 0);
        return;
      end
    end
  endtask

  // monitor: pops the scoreboard on every output handshake
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && !flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got tag %0d data 0x%h, required no output", out_tag, out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e[31:0]);
          chk("out_tag", out_tag, e[36:32]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // 1: SRA negative with latency check
    send(2'b10, 32'h8000_0000, 5'd4, 5'd3, 32'hF800_0000);
    chk("lat_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 32'hF800_0000);
    chk("lat_tag", out_tag, 5'd3);
    drain();

    // 2: directed vectors, back-to-back, levels in either stage
    send(2'b00, 32'h0000_0001, 5'd31, 5'd4,  32'h8000_0000);
    send(2'b01, 32'hF000_0000, 5'd4,  5'd5,  32'h0F00_0000);
    send(2'b00, 32'h1234_5678, 5'd0,  5'd6,  32'h1234_5678);
    send(2'b01, 32'h89AB_CDEF, 5'd0,  5'd7,  32'h89AB_CDEF);
    send(2'b10, 32'h8000_0001, 5'd0,  5'd8,  32'h8000_0001);
    send(2'b10, 32'h7FFF_FFF0, 5'd4,  5'd9,  32'h07FF_FFFF);
    send(2'b01, 32'h8000_0000, 5'd31, 5'd10, 32'h0000_0001);
    send(2'b10, 32'h8000_0000, 5'd31, 5'd11, 32'hFFFF_FFFF);
    send(2'b00, 32'hFFFF_FFFF, 5'd16, 5'd12, 32'hFFFF_0000);
    // 4: rotate (or zero result when rotate is not built in)
    send(2'b11, 32'h0000_0001, 5'd1,  5'd13, ROR_EN ? 32'h8000_0000 : 32'h0);
    send(2'b11, 32'h1234_5678, 5'd8,  5'd14, ROR_EN ? 32'h7812_3456 : 32'h0);
    drain();

    // 3: stream of 4 with a 3-cycle output stall
    fork
      begin
        send(2'b00, 32'h0000_000F, 5'd4,  5'd20, 32'h0000_00F0);
        send(2'b01, 32'h0000_00F0, 5'd4,  5'd21, 32'h0000_000F);
        send(2'b10, 32'hFFFF_0000, 5'd8,  5'd22, 32'hFFFF_FF00);
        send(2'b00, 32'h0000_00A5, 5'd24, 5'd23, 32'hA500_0000);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        logic saw_low;
        saw_low = 1'b0;
        repeat (2) @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_hold_data", out_data, 32'h0000_00F0);
          chk("stall_hold_tag", out_tag, 5'd20);
          if (!in_ready) saw_low = 1'b1;
        end
        chk("stall_in_ready_low", saw_low, 1);
      end
    join
    drain();

    // 5: flush with two ops in flight, simultaneous output handshake and input
    out_ready = 1'b0;
    send(2'b01, 32'h0000_0100, 5'd4, 5'd24, 32'h0000_0010);
    send(2'b01, 32'h0000_0200, 5'd4, 5'd25, 32'h0000_0020);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'h1; in_shamt = 5'd1; in_tag = 5'd26;
    #1 chk("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", out_valid, 0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("flush_quiet", out_valid, 0);
    end
    send(2'b01, 32'h0000_0100, 5'd8, 5'd27, 32'h0000_0001);
    drain();

    // 6: asynchronous reset with full, stalled pipe
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0001, 5'd1, 5'd28, 32'h0000_0002);
    send(2'b00, 32'h0000_0001, 5'd2, 5'd29, 32'h0000_0004);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("arst_in_ready", in_ready, 1);
    send(2'b10, 32'hFFFF_FF00, 5'd8, 5'd30, 32'hFFFF_FFFF);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
